// File: rtl/sw_result_collector_pkg.sv
// Shared widths, record layout and FSM states for the Smith-Waterman result collector.
// Optional macro SW_COLLECT_TIMESTAMP_EN appends a 16-bit cycle stamp as the record LSB field.
package sw_result_collector_pkg;

  localparam int CALC_BIT   = 12;
  localparam int T_IDX_BIT  = 10;
  localparam int Q_IDX_BIT  = 8;
  localparam int HIT_BIT    = 8;
  localparam int FIFO_DEPTH = 4;

`ifdef SW_COLLECT_TIMESTAMP_EN
  localparam int TS_FIELD_BIT = 16;
`else
  localparam int TS_FIELD_BIT = 0;
`endif

  // Record layout, MSB first: {q_idx, max, match_idx, hit_cnt[, timestamp]}
  localparam int HIT_LSB      = TS_FIELD_BIT;
  localparam int IDX_LSB      = HIT_LSB + HIT_BIT;
  localparam int MAX_LSB      = IDX_LSB + T_IDX_BIT;
  localparam int Q_LSB        = MAX_LSB + CALC_BIT;
  localparam int REC_BIT      = Q_LSB + Q_IDX_BIT;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } coll_state_e;

endpackage

// File: rtl/sw_result_collector_if.sv
// Record stream from the collector to the host: valid/ready with one record per beat.
interface sw_result_collector_if
  import sw_result_collector_pkg::*;
#(
  parameter int REC_W = REC_BIT
) ();

  logic             rec_valid;
  logic             rec_ready;
  logic [REC_W-1:0] rec_data;

  modport master (output rec_valid, output rec_data, input rec_ready);
  modport slave  (input rec_valid, input rec_data, output rec_ready);

endinterface

// File: rtl/sw_result_collector_fifo.sv
// sw_record_fifo: synchronous FIFO; a push into a full FIFO succeeds only alongside a pop.
module sw_record_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head forced to zero when empty so the idle output never shows stale records
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !(rst || clear)) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sw_result_collector.sv
// Collects per-query summaries from the SW array into records and streams them to the host.
// Optional macro SW_COLLECT_TIMESTAMP_EN adds a saturating 16-bit cycle stamp to each record.
module sw_result_collector
  import sw_result_collector_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic                        sw_busy_i,
  input  logic signed [CALC_BIT-1:0]  threshold_i,
  input  logic signed [CALC_BIT-1:0]  result_i,
  input  logic                        valid_i,
  input  logic signed [CALC_BIT-1:0]  max_result_i,
  input  logic [T_IDX_BIT-1:0]        match_idx_i,
  input  logic                        change_q_i,
  sw_result_collector_if.master       rec_if,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        overflow_o
);

  coll_state_e                state;
  coll_state_e                state_next;
  logic signed [CALC_BIT-1:0] threshold_r;
  logic [Q_IDX_BIT-1:0]       q_idx;
  logic [HIT_BIT-1:0]         hit_cnt;
  logic [HIT_BIT-1:0]         hit_cnt_next;
  logic                       seen_busy;
  logic                       busy_q;
  logic                       overflow_q;
  logic                       run_start;
  logic                       in_run;
  logic                       hit;
  logic                       rec_push;
  logic                       rec_pop;
  logic                       rec_drop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [REC_BIT-1:0]         rec_word;

  assign run_start    = (state == ST_IDLE) && start_i;
  assign in_run       = (state == ST_RUN);
  assign hit          = in_run && valid_i && (result_i >= threshold_r);
  assign hit_cnt_next = (hit && !(&hit_cnt)) ? hit_cnt + HIT_BIT'(1) : hit_cnt;
  assign rec_push     = in_run && change_q_i;
  assign rec_pop      = rec_if.rec_valid && rec_if.rec_ready;
  assign rec_drop     = rec_push && fifo_full && !rec_pop;

  assign rec_if.rec_valid = !fifo_empty;
  assign busy_o           = busy_q;
  assign overflow_o       = overflow_q;

`ifdef SW_COLLECT_TIMESTAMP_EN
  logic [TS_FIELD_BIT-1:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (rst || run_start)  ts_cnt <= '0;
    else if (!(&ts_cnt))   ts_cnt <= ts_cnt + TS_FIELD_BIT'(1);
  end
`endif

  always_comb begin
    rec_word = '0;
    rec_word[Q_LSB   +: Q_IDX_BIT] = q_idx;
    rec_word[MAX_LSB +: CALC_BIT]  = max_result_i;
    rec_word[IDX_LSB +: T_IDX_BIT] = match_idx_i;
    rec_word[HIT_LSB +: HIT_BIT]   = hit_cnt_next;
`ifdef SW_COLLECT_TIMESTAMP_EN
    rec_word[0 +: TS_FIELD_BIT]    = ts_cnt;
`endif
  end

  sw_record_fifo #(
    .WIDTH (REC_BIT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (run_start),
    .push  (rec_push),
    .pop   (rec_pop),
    .wdata (rec_word),
    .rdata (rec_if.rec_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // RUN ends only on a busy fall, so a run whose array has not yet raised busy keeps waiting
  always_comb begin
    state_next = state;
    done_o     = 1'b0;
    case (state)
      ST_IDLE:  if (start_i) state_next = ST_RUN;
      ST_RUN:   if (seen_busy && !sw_busy_i) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (fifo_count == '0) begin
          done_o     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      threshold_r <= '0;
      q_idx       <= '0;
      hit_cnt     <= '0;
      seen_busy   <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      busy_q <= (state_next != ST_IDLE);
      if (run_start) begin
        threshold_r <= threshold_i;
        q_idx       <= '0;
        hit_cnt     <= '0;
        seen_busy   <= 1'b0;
        overflow_q  <= 1'b0;
      end else if (in_run) begin
        if (sw_busy_i) seen_busy <= 1'b1;
        if (rec_push) begin
          hit_cnt <= '0;
          q_idx   <= q_idx + Q_IDX_BIT'(1);
          if (rec_drop) overflow_q <= 1'b1;
        end else begin
          hit_cnt <= hit_cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_sw_result_collector.sv
// Randomized bench for sw_result_collector against a queue-based reference of the record stream.
// Honours SW_COLLECT_TIMESTAMP_EN so the same bench covers both record formats.
module tb_sw_result_collector;
  import sw_result_collector_pkg::*;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       start;
  logic                       sw_busy;
  logic signed [CALC_BIT-1:0] threshold;
  logic signed [CALC_BIT-1:0] result;
  logic                       valid;
  logic signed [CALC_BIT-1:0] max_result;
  logic [T_IDX_BIT-1:0]       match_idx;
  logic                       change_q;
  logic                       busy;
  logic                       done;
  logic                       overflow;

  sw_result_collector_if rif ();

  sw_result_collector dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .sw_busy_i    (sw_busy),
    .threshold_i  (threshold),
    .result_i     (result),
    .valid_i      (valid),
    .max_result_i (max_result),
    .match_idx_i  (match_idx),
    .change_q_i   (change_q),
    .rec_if       (rif),
    .busy_o       (busy),
    .done_o       (done),
    .overflow_o   (overflow)
  );

  always #5 clk = ~clk;

  logic [63:0] m_q[$];
  int          m_phase = M_IDLE;
  int          m_qn    = 0;
  int          m_hits  = 0;
  int          m_thr   = 0;
  int          m_ts    = 0;
  bit          m_ovf   = 1'b0;
  bit          m_seen  = 1'b0;
  int          total   = 0;
  int          bad     = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [63:0] mkRec(input int qn, input int mx, input int idx, input int h, input int ts);
    logic [63:0] r;
    r = (64'(qn & 255) << 30) | (64'(mx & 4095) << 18) | (64'(idx & 1023) << 8) | 64'(h & 255);
    if (TS_FIELD_BIT > 0) r = (r << TS_FIELD_BIT) | 64'(ts & 65535);
    return r;
  endfunction

  // Reference: one cycle of the collector's behaviour given the inputs just driven
  task automatic modelStep();
    int  res;
    int  h;
    bit  pop;
    bit  was_start;
    res = result;
    if (rst) begin
      m_phase = M_IDLE; m_q.delete(); m_qn = 0; m_hits = 0; m_thr = 0;
      m_ovf = 1'b0; m_seen = 1'b0; m_ts = 0;
      return;
    end
    pop       = (m_q.size() > 0) && rif.rec_ready;
    was_start = (m_phase == M_IDLE) && start;
    case (m_phase)
      M_IDLE: begin
        if (start) begin
          m_thr = threshold; m_qn = 0; m_hits = 0; m_ovf = 1'b0;
          m_q.delete(); m_seen = 1'b0; m_phase = M_RUN;
        end
      end
      M_RUN: begin
        h = m_hits;
        if (valid && res >= m_thr && h < 255) h++;
        if (pop) void'(m_q.pop_front());
        if (change_q) begin
          if (m_q.size() < FIFO_DEPTH) m_q.push_back(mkRec(m_qn, max_result, match_idx, h, m_ts));
          else m_ovf = 1'b1;
          m_qn = (m_qn + 1) % 256;
          m_hits = 0;
        end else begin
          m_hits = h;
        end
        if (m_seen && !sw_busy) m_phase = M_DRAIN;
        else if (sw_busy) m_seen = 1'b1;
      end
      default: begin
        if (m_q.size() == 0) m_phase = M_IDLE;
        else if (pop) void'(m_q.pop_front());
      end
    endcase
    if (was_start) m_ts = 0;
    else if (m_ts < 65535) m_ts++;
  endtask

  task automatic nextCycle();
    @(negedge clk);
    checkOutput("rec_valid", rif.rec_valid, m_q.size() != 0);
    checkOutput("rec_data", rif.rec_data, (m_q.size() != 0) ? m_q[0] : 64'd0);
    checkOutput("busy", busy, m_phase != M_IDLE);
    checkOutput("done", done, (m_phase == M_DRAIN) && (m_q.size() == 0));
    checkOutput("overflow", overflow, m_ovf);
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit b, input int thr, input bit v,
                               input int res, input int mx, input int idx, input bit c, input bit rdy);
    rst = r; start = s; sw_busy = b;
    threshold  = CALC_BIT'(thr);
    valid = v;
    result     = CALC_BIT'(res);
    max_result = CALC_BIT'(mx);
    match_idx  = T_IDX_BIT'(idx);
    change_q = c;
    rif.rec_ready = rdy;
    modelStep();
  endtask

  task automatic drive(input bit r, input bit s, input bit b, input int thr, input bit v,
                       input int res, input int mx, input int idx, input bit c, input bit rdy);
    nextCycle();
    applyStimulus(r, s, b, thr, v, res, mx, idx, c, rdy);
  endtask

  task automatic randCycle(input bit b, input int chg_pct, input int rdy_pct, input int start_pct);
    int res;
    if ($urandom_range(0, 1) == 0) res = m_thr + int'($urandom_range(0, 8)) - 4;
    else                           res = int'($urandom_range(0, 4095)) - 2048;
    drive(1'b0, $urandom_range(0, 99) < start_pct, b, int'($urandom_range(0, 4095)) - 2048,
          $urandom_range(0, 99) < 70, res, int'($urandom_range(0, 4095)) - 2048,
          int'($urandom_range(0, 1023)), $urandom_range(0, 99) < chg_pct,
          $urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic drainRun(input int rdy_pct);
    for (int i = 0; i < 300 && m_phase != M_IDLE; i++) randCycle(1'b0, 20, rdy_pct, 10);
  endtask

  initial begin
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Basic query, same-cycle hit, full-with-pop and overflow in one run
    drive(0, 1, 0, 5, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 1, 3, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 1, 5, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 1, 7, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 1, 4, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 7, 2, 1, 0);
    nextCycle();
    checkOutput("basic_rec", 64'(rif.rec_data) >> TS_FIELD_BIT, 64'h1C0202);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 1, 6, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 1, 9, 9, 3, 1, 0);
    nextCycle();
    checkOutput("samecycle_rec", 64'(rif.rec_data) >> TS_FIELD_BIT, 64'h40240302);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 0, 0, 100 + i, 10 + i, 1, 0);
    drive(0, 0, 1, 0, 0, 0, -300, 999, 1, 1);
    nextCycle();
    checkOutput("fullpop_ovf", overflow, 1'b0);
    checkOutput("fullpop_valid", rif.rec_valid, 1'b1);
    applyStimulus(0, 0, 1, 0, 0, 0, 55, 66, 1, 0);
    nextCycle();
    checkOutput("overflow_set", overflow, 1'b1);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, i[0]);

    // Hit-count saturation with the most negative threshold
    drive(0, 1, 0, -2048, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) randCycle(1'b1, 0, 100, 0);
    drive(0, 0, 1, 0, 1, 0, 12, 34, 1, 1);
    drainRun(100);

    // Query index wrap past 255
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) randCycle(1'b1, (i % 2 == 0) ? 100 : 0, 100, 5);
    drainRun(100);

    // Random runs, some interrupted by reset
    for (int run = 0; run < 30; run++) begin
      int rdy_pct;
      int len;
      rdy_pct = int'($urandom_range(15, 100));
      len     = int'($urandom_range(10, 60));
      for (int i = 0; i < 3; i++) randCycle(1'b0, 20, rdy_pct, 0);
      drive(0, 1, 0, int'($urandom_range(0, 4095)) - 2048, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < len; i++) begin
        if (run % 5 == 2 && i == len / 2) begin
          drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
          break;
        end
        randCycle(1'b1, 25, rdy_pct, 5);
      end
      drainRun(rdy_pct);
    end

    nextCycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
